// File: rtl/uart_tx_param_pkg.sv
// uart_tx_param_pkg: shared parity and FSM state encodings for the UART transmitter
package uart_tx_param_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering words ahead of the serialiser
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter with configurable data, parity and stop bits
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        i_tx_d,
  input  logic                        i_tx_en,
  output logic                        o_tx_ready,
  output logic                        o_tx_overflow,
  output logic                        o_tx_busy,
  output logic                        o_tx_complete,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_tx_d
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [3:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n, head;
  logic par, par_n, pop, full, empty, bit_end, last_data, last_stop;
  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(i_tx_en),
    .din(i_tx_d),
    .pop(pop),
    .dout(head),
    .level(o_fifo_level),
    .full(full),
    .empty(empty)
  );
  assign o_tx_ready = !full;
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end && last_stop));
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    shift_n = shift;
    par_n = par;
    baud_n = (state == IDLE || bit_end) ? '0 : baud + 1'b1;
    if (pop) begin
      state_n = START;
      shift_n = head;
      par_n = ^head;
      bit_n = '0;
    end else if (bit_end)
      case (state)
        START: state_n = DATA;
        DATA: begin
          shift_n = shift >> 1;
          bit_n = last_data ? '0 : bit_cnt + 1'b1;
          state_n = !last_data ? DATA : PARITY_MODE != PARITY_NONE ? PARITY : STOP;
        end
        PARITY: state_n = STOP;
        STOP: begin
          bit_n = last_stop ? '0 : bit_cnt + 1'b1;
          state_n = last_stop ? IDLE : STOP;
        end
        default: state_n = state;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      o_tx_d <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_complete <= 1'b0;
      o_tx_overflow <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      par <= par_n;
      o_tx_d <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] :
                state_n == PARITY ? par_n ^ (PARITY_MODE == PARITY_ODD) : 1'b1;
      o_tx_busy <= state_n != IDLE;
      o_tx_complete <= state_n == STOP && baud_n == BW'(CLKS_PER_BIT - 1) && bit_n == 4'(STOP_BITS - 1);
      o_tx_overflow <= i_tx_en && full;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four frame formats checked cycle by cycle against a frame-level reference model
module tb_uart_tx_param;
  localparam int CPB = 4;
  localparam int N = 4;
  localparam int DB [N] = '{8, 8, 8, 7};
  localparam int PM [N] = '{0, 2, 1, 0};
  localparam int SB [N] = '{1, 2, 1, 1};
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [8:0] din = '0;
  logic line [N], busy [N], done [N], ovf [N], rdy [N];
  logic [2:0] lvl [N];
  int vecs = 0, fails = 0, cyc = 0, n_done = 0, n_ovf = 0;
  logic [8:0] qm [N][4];
  int qn [N], fs [N], fe [N];
  logic fb [N][16];
  logic ovf_x [N];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS(DB[g]),
      .PARITY_MODE(PM[g]),
      .STOP_BITS(SB[g]),
      .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .i_tx_d(din[DB[g]-1:0]),
      .i_tx_en(en),
      .o_tx_ready(rdy[g]),
      .o_tx_overflow(ovf[g]),
      .o_tx_busy(busy[g]),
      .o_tx_complete(done[g]),
      .o_fifo_level(lvl[g]),
      .o_tx_d(line[g])
    );
  end
  task automatic chk(input string tag, input int k, input logic [8:0] got, input logic [8:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, k, cyc, got, exp);
    end
  endtask
  task automatic load_frame(input int k, input logic [8:0] w);
    int n;
    fb[k][0] = 1'b0;
    n = 1;
    for (int i = 0; i < DB[k]; i++) begin
      fb[k][n] = w[i];
      n++;
    end
    if (PM[k] != 0) begin
      fb[k][n] = PM[k] == 2 ? ^w : ~^w;
      n++;
    end
    for (int i = 0; i < SB[k]; i++) begin
      fb[k][n] = 1'b1;
      n++;
    end
    fs[k] = cyc + 1;
    fe[k] = cyc + n * CPB;
  endtask
  task automatic step(input logic r, input logic e, input logic [8:0] d);
    logic [8:0] w;
    bit acc, act;
    rst = r;
    en = e;
    din = d;
    for (int k = 0; k < N; k++) begin
      w = d & 9'((1 << DB[k]) - 1);
      ovf_x[k] = 1'b0;
      if (r) begin
        qn[k] = 0;
        fs[k] = 0;
        fe[k] = -1;
      end else begin
        acc = e && qn[k] < 4;
        ovf_x[k] = e && !acc;
        if (qn[k] > 0 && fe[k] <= cyc) begin
          load_frame(k, qm[k][0]);
          for (int i = 0; i < 3; i++) qm[k][i] = qm[k][i+1];
          qn[k]--;
        end
        if (acc) begin
          qm[k][qn[k]] = w;
          qn[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      act = cyc >= fs[k] && cyc <= fe[k];
      chk("line", k, 9'(line[k]), act ? 9'(fb[k][(cyc - fs[k]) / CPB]) : 9'd1);
      chk("busy", k, 9'(busy[k]), 9'(act));
      chk("complete", k, 9'(done[k]), 9'(cyc == fe[k]));
      chk("overflow", k, 9'(ovf[k]), 9'(ovf_x[k]));
      chk("level", k, 9'(lvl[k]), 9'(qn[k]));
      chk("ready", k, 9'(rdy[k]), 9'(qn[k] < 4));
    end
    if (done[0] === 1'b1) n_done++;
    if (ovf[0] === 1'b1) n_ovf++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'($urandom));
  endtask
  initial begin
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 9'h0A5);
    step(1'b0, 1'b1, 9'h0A5);
    idle(60);
    step(1'b0, 1'b1, 9'h007);
    idle(60);
    n_done = 0;
    step(1'b0, 1'b1, 9'h011);
    step(1'b0, 1'b1, 9'h022);
    step(1'b0, 1'b1, 9'h033);
    idle(170);
    chk("complete_count", 0, 9'(n_done), 9'd3);
    n_ovf = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 9'($urandom));
    idle(260);
    chk("overflow_count", 0, 9'(n_ovf), 9'd1);
    step(1'b0, 1'b1, 9'h1FF);
    step(1'b0, 1'b1, 9'($urandom));
    step(1'b0, 1'b1, 9'($urandom));
    idle(15);
    n_done = 0;
    step(1'b1, 1'b0, 9'($urandom));
    idle(60);
    chk("complete_after_reset", 0, 9'(n_done), 9'd0);
    step(1'b0, 1'b1, 9'h055);
    idle(50);
    for (int i = 0; i < 80; i++) step(1'b0, 1'($urandom_range(0, 2) == 0), 9'($urandom));
    idle(320);
    step(1'b1, 1'b0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
